// File: rtl/segre_pkg.sv
// Shared types for the memory-port arbiter: FSM states, grant codes and store sizes.
package segre_pkg;

    localparam int unsigned LINE_OFFSET_BITS = 4;
    localparam logic        TURN_DATA        = 1'b0;

    typedef enum logic [1:0] {
        MEMOP_BYTE  = 2'b00,
        MEMOP_HALF  = 2'b01,
        MEMOP_WORD  = 2'b10
    } memop_data_type_e;

    typedef enum logic [2:0] {
        MMU_IDLE    = 3'd0,
        DCACHE_REQ  = 3'd1,
        DCACHE_WAIT = 3'd2,
        ICACHE_REQ  = 3'd3,
        ICACHE_WAIT = 3'd4,
        SB_REQ      = 3'd5,
        SB_WAIT     = 3'd6
    } mmu_fsm_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DC   = 2'd1,
        GNT_IC   = 2'd2,
        GNT_SB   = 2'd3
    } mem_arb_grant_e;

    function automatic logic is_wait_state(input mmu_fsm_state_e s);
        return (s == DCACHE_WAIT) || (s == ICACHE_WAIT) || (s == SB_WAIT);
    endfunction

endpackage

// File: rtl/segre_mem_arb_prio.sv
// Combinational grant selector: store-before-fill on a line match, dc-before-sb otherwise,
// and a turn bit alternating the data side against instruction fetch.
module segre_mem_arb_prio
    import segre_pkg::*;
(
    input  logic           i_dc_req,
    input  logic           i_ic_req,
    input  logic           i_sb_req,
    input  logic           i_line_match,
    input  logic           i_turn,
    output mem_arb_grant_e o_grant_c
);

    logic w_data_req;
    logic w_sb_wins;
    logic w_data_turn;

    assign w_data_req  = i_dc_req | i_sb_req;
    assign w_sb_wins   = i_sb_req & (~i_dc_req | i_line_match);
    assign w_data_turn = (i_turn == TURN_DATA);

    // A lone requester wins regardless of whose turn it is.
    always_comb begin
        o_grant_c = GNT_NONE;
        if (w_data_req && (!i_ic_req || w_data_turn)) begin
            o_grant_c = w_sb_wins ? GNT_SB : GNT_DC;
        end else if (i_ic_req) begin
            o_grant_c = GNT_IC;
        end
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Shares one memory port between dcache fills, icache fills and store-buffer drains.
// Define SEGRE_MEM_ARB_TIMEOUT_EN to add the WAIT watchdog that reissues a stalled request.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int unsigned ADDR_SIZE      = 32,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned LANE_SIZE      = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,

    input  logic                 dc_miss_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    output logic                 dc_mmu_data_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,

    input  logic                 ic_miss_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_mmu_data_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,

    input  logic                 sb_req_i,
    input  logic [ADDR_SIZE-1:0] sb_addr_i,
    input  logic [WORD_SIZE-1:0] sb_data_i,
    input  logic [1:0]           sb_data_type_i,
    output logic                 sb_ack_o,

    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WORD_SIZE-1:0] mem_wr_data_o,
    output logic [1:0]           mem_data_type_o,
    input  logic                 mem_rdy_i,
    input  logic [LANE_SIZE-1:0] mem_data_i,

    output logic                 busy_o,
    output logic                 timeout_o
);

    mmu_fsm_state_e       r_state;
    logic                 r_turn;
    logic                 r_mem_rd;
    logic                 r_mem_wr;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic [WORD_SIZE-1:0] r_wr_data;
    logic [1:0]           r_data_type;
    logic                 r_dc_rdy;
    logic                 r_ic_rdy;
    logic                 r_sb_ack;
    logic [LANE_SIZE-1:0] r_dc_data;
    logic [LANE_SIZE-1:0] r_ic_data;
    logic                 r_busy;

    logic                 w_dc_req;
    logic                 w_ic_req;
    logic                 w_sb_req;
    logic                 w_line_match;
    logic [ADDR_SIZE-1:0] w_dc_fill_addr;
    logic [ADDR_SIZE-1:0] w_ic_fill_addr;
    logic                 w_expire;
    logic                 w_unused;
    mem_arb_grant_e       w_grant;

    // A requester is still holding its level during its done pulse; mask it for that cycle.
    assign w_dc_req = dc_miss_i & ~r_dc_rdy;
    assign w_ic_req = ic_miss_i & ~r_ic_rdy;
    assign w_sb_req = sb_req_i  & ~r_sb_ack;

    assign w_line_match   = (sb_addr_i[ADDR_SIZE-1:LINE_OFFSET_BITS] ==
                             dc_addr_i[ADDR_SIZE-1:LINE_OFFSET_BITS]);
    assign w_dc_fill_addr = {dc_addr_i[ADDR_SIZE-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};
    assign w_ic_fill_addr = {ic_addr_i[ADDR_SIZE-1:LINE_OFFSET_BITS], LINE_OFFSET_BITS'(0)};

    assign w_unused = ^{dc_addr_i[LINE_OFFSET_BITS-1:0], ic_addr_i[LINE_OFFSET_BITS-1:0],
                        TIMEOUT_CYCLES[0]};

    segre_mem_arb_prio u_prio (
        .i_dc_req     (w_dc_req),
        .i_ic_req     (w_ic_req),
        .i_sb_req     (w_sb_req),
        .i_line_match (w_line_match),
        .i_turn       (r_turn),
        .o_grant_c    (w_grant)
    );

`ifdef SEGRE_MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;
    logic             w_in_wait;

    assign w_in_wait = is_wait_state(r_state);
    assign w_expire  = w_in_wait & ~mem_rdy_i & (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts WAIT cycles of the current attempt; the timeout flag is sticky until reset.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_in_wait && !mem_rdy_i) begin
            if (w_expire) begin
                r_wait_cnt <= '0;
                r_timeout  <= 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Transaction sequencer: IDLE -> REQ (strobe) -> WAIT -> IDLE with done pulse.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state     <= MMU_IDLE;
            r_turn      <= TURN_DATA;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_wr_data   <= '0;
            r_data_type <= '0;
            r_dc_rdy    <= 1'b0;
            r_ic_rdy    <= 1'b0;
            r_sb_ack    <= 1'b0;
            r_dc_data   <= '0;
            r_ic_data   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_dc_rdy <= 1'b0;
            r_ic_rdy <= 1'b0;
            r_sb_ack <= 1'b0;
            case (r_state)
                MMU_IDLE: begin
                    case (w_grant)
                        GNT_DC: begin
                            r_state    <= DCACHE_REQ;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= w_dc_fill_addr;
                            r_busy     <= 1'b1;
                            r_turn     <= ~r_turn;
                        end
                        GNT_IC: begin
                            r_state    <= ICACHE_REQ;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= w_ic_fill_addr;
                            r_busy     <= 1'b1;
                            r_turn     <= ~r_turn;
                        end
                        GNT_SB: begin
                            r_state     <= SB_REQ;
                            r_mem_wr    <= 1'b1;
                            r_mem_addr  <= sb_addr_i;
                            r_wr_data   <= sb_data_i;
                            r_data_type <= sb_data_type_i;
                            r_busy      <= 1'b1;
                            r_turn      <= ~r_turn;
                        end
                        default: r_busy <= 1'b0;
                    endcase
                end
                DCACHE_REQ: r_state <= DCACHE_WAIT;
                ICACHE_REQ: r_state <= ICACHE_WAIT;
                SB_REQ:     r_state <= SB_WAIT;
                DCACHE_WAIT: begin
                    if (mem_rdy_i) begin
                        r_state   <= MMU_IDLE;
                        r_dc_rdy  <= 1'b1;
                        r_dc_data <= mem_data_i;
                        r_busy    <= 1'b0;
                    end else if (w_expire) begin
                        r_state  <= DCACHE_REQ;
                        r_mem_rd <= 1'b1;
                    end
                end
                ICACHE_WAIT: begin
                    if (mem_rdy_i) begin
                        r_state   <= MMU_IDLE;
                        r_ic_rdy  <= 1'b1;
                        r_ic_data <= mem_data_i;
                        r_busy    <= 1'b0;
                    end else if (w_expire) begin
                        r_state  <= ICACHE_REQ;
                        r_mem_rd <= 1'b1;
                    end
                end
                SB_WAIT: begin
                    if (mem_rdy_i) begin
                        r_state  <= MMU_IDLE;
                        r_sb_ack <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (w_expire) begin
                        r_state  <= SB_REQ;
                        r_mem_wr <= 1'b1;
                    end
                end
                default: begin
                    r_state <= MMU_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dc_mmu_data_rdy_o = r_dc_rdy;
    assign dc_data_o         = r_dc_data;
    assign ic_mmu_data_rdy_o = r_ic_rdy;
    assign ic_data_o         = r_ic_data;
    assign sb_ack_o          = r_sb_ack;
    assign mem_rd_o          = r_mem_rd;
    assign mem_wr_o          = r_mem_wr;
    assign mem_addr_o        = r_mem_addr;
    assign mem_wr_data_o     = r_wr_data;
    assign mem_data_type_o   = r_data_type;
    assign busy_o            = r_busy;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: transaction-level model checked every cycle plus directed
// scenarios with literal expectations; the watchdog scenario needs SEGRE_MEM_ARB_TIMEOUT_EN.
module tb_segre_mem_arbiter;
    import segre_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned LW = 128;
    localparam int unsigned TO = 8;
    localparam int O_DC = 0;
    localparam int O_IC = 1;
    localparam int O_SB = 2;

    logic          clk = 1'b0;
    logic          rsn;
    logic          dc_miss_i, ic_miss_i, sb_req_i, mem_rdy_i;
    logic [AW-1:0] dc_addr_i, ic_addr_i, sb_addr_i;
    logic [WW-1:0] sb_data_i;
    logic [1:0]    sb_data_type_i;
    logic [LW-1:0] mem_data_i;
    logic          dc_mmu_data_rdy_o, ic_mmu_data_rdy_o, sb_ack_o;
    logic [LW-1:0] dc_data_o, ic_data_o;
    logic          mem_rd_o, mem_wr_o, busy_o, timeout_o;
    logic [AW-1:0] mem_addr_o;
    logic [WW-1:0] mem_wr_data_o;
    logic [1:0]    mem_data_type_o;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    segre_mem_arbiter #(
        .ADDR_SIZE(AW), .WORD_SIZE(WW), .LANE_SIZE(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rsn_i(rsn),
        .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i),
        .dc_mmu_data_rdy_o(dc_mmu_data_rdy_o), .dc_data_o(dc_data_o),
        .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
        .ic_mmu_data_rdy_o(ic_mmu_data_rdy_o), .ic_data_o(ic_data_o),
        .sb_req_i(sb_req_i), .sb_addr_i(sb_addr_i), .sb_data_i(sb_data_i),
        .sb_data_type_i(sb_data_type_i), .sb_ack_o(sb_ack_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_data_type_o(mem_data_type_o),
        .mem_rdy_i(mem_rdy_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {a, ~a, a + 32'd1, 32'hA5A5_5A5A};
    endfunction

    // Memory responder: answers each strobe after mem_lat extra WAIT cycles unless told to drop it.
    int mem_lat = 0;
    int hold_n  = 0;
    always @(negedge clk) begin
        if (rsn && (mem_rd_o || mem_wr_o)) begin
            logic [AW-1:0] a;
            a = mem_addr_o;
            if (hold_n > 0) begin
                hold_n--;
            end else begin
                repeat (mem_lat + 1) @(posedge clk);
                #1;
                mem_rdy_i  = 1'b1;
                mem_data_i = line_of(a);
                @(posedge clk);
                #1;
                mem_rdy_i  = 1'b0;
                mem_data_i = '0;
            end
        end
    end

    // Event log for the directed literal checks.
    int unsigned   ev_cyc[$];
    logic [AW-1:0] ev_addr[$];
    bit            ev_wr[$];
    logic [WW-1:0] ev_wdata[$];
    int unsigned   dc_done_cyc[$];
    int unsigned   ic_done_cyc[$];
    int unsigned   sb_ack_cyc[$];
    always @(negedge clk) begin
        if (mem_rd_o || mem_wr_o) begin
            ev_cyc.push_back(cyc);
            ev_addr.push_back(mem_addr_o);
            ev_wr.push_back(mem_wr_o);
            ev_wdata.push_back(mem_wr_data_o);
        end
        if (dc_mmu_data_rdy_o) dc_done_cyc.push_back(cyc);
        if (ic_mmu_data_rdy_o) ic_done_cyc.push_back(cyc);
        if (sb_ack_o)          sb_ack_cyc.push_back(cyc);
    end

    // Transaction-level reference: one outstanding transaction, issued, waited on, retired.
    bit            m_busy, m_issue, m_turn, m_dc_done, m_ic_done, m_sb_ack, m_timeout;
    int            m_owner, m_wait;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_wdata;
    logic [1:0]    m_dtype;
    logic [LW-1:0] m_dc_line, m_ic_line;

    always @(posedge clk or negedge rsn) begin
        if (!rsn) begin
            m_busy = 0; m_issue = 0; m_turn = 0; m_timeout = 0;
            m_dc_done = 0; m_ic_done = 0; m_sb_ack = 0;
            m_owner = 0; m_wait = 0; m_addr = '0; m_wdata = '0; m_dtype = '0;
            m_dc_line = '0; m_ic_line = '0;
        end else begin
            bit want_dc, want_ic, want_sb;
            int who;
            want_dc = dc_miss_i && !m_dc_done;
            want_ic = ic_miss_i && !m_ic_done;
            want_sb = sb_req_i && !m_sb_ack;
            m_dc_done = 0; m_ic_done = 0; m_sb_ack = 0;
            if (!m_busy) begin
                who = -1;
                if ((want_dc || want_sb) && (!want_ic || !m_turn))
                    who = (want_sb && (!want_dc || (sb_addr_i >> 4) == (dc_addr_i >> 4))) ? O_SB : O_DC;
                else if (want_ic)
                    who = O_IC;
                if (who >= 0) begin
                    m_busy = 1; m_issue = 1; m_owner = who; m_wait = 0; m_turn = !m_turn;
                    if (who == O_DC) m_addr = dc_addr_i & ~AW'(15);
                    else if (who == O_IC) m_addr = ic_addr_i & ~AW'(15);
                    else begin
                        m_addr = sb_addr_i; m_wdata = sb_data_i; m_dtype = sb_data_type_i;
                    end
                end
            end else if (m_issue) begin
                m_issue = 0;
                m_wait  = 0;
            end else if (mem_rdy_i) begin
                m_busy = 0;
                if (m_owner == O_DC) begin m_dc_done = 1; m_dc_line = mem_data_i; end
                else if (m_owner == O_IC) begin m_ic_done = 1; m_ic_line = mem_data_i; end
                else m_sb_ack = 1;
            end else begin
                m_wait++;
`ifdef SEGRE_MEM_ARB_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_timeout = 1;
                    m_issue   = 1;
                end
`endif
            end
        end
    end

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        chk("busy", LW'(busy_o), LW'(m_busy));
        chk("mem_rd", LW'(mem_rd_o), LW'(m_issue && m_owner != O_SB));
        chk("mem_wr", LW'(mem_wr_o), LW'(m_issue && m_owner == O_SB));
        if (m_busy) chk("mem_addr", LW'(mem_addr_o), LW'(m_addr));
        if (m_busy && m_owner == O_SB) begin
            chk("mem_wr_data", LW'(mem_wr_data_o), LW'(m_wdata));
            chk("mem_data_type", LW'(mem_data_type_o), LW'(m_dtype));
        end
        chk("dc_rdy", LW'(dc_mmu_data_rdy_o), LW'(m_dc_done));
        chk("ic_rdy", LW'(ic_mmu_data_rdy_o), LW'(m_ic_done));
        chk("sb_ack", LW'(sb_ack_o), LW'(m_sb_ack));
        chk("dc_data", dc_data_o, m_dc_line);
        chk("ic_data", ic_data_o, m_ic_line);
        chk("timeout", LW'(timeout_o), LW'(m_timeout));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ev_cyc.delete(); ev_addr.delete(); ev_wr.delete(); ev_wdata.delete();
        dc_done_cyc.delete(); ic_done_cyc.delete(); sb_ack_cyc.delete();
    endtask

    task automatic do_reset();
        rsn = 1'b0;
        repeat (2) tick();
        rsn = 1'b1;
        clear_logs();
    endtask

    // Runs until every requester has been served and dropped; requesters drop after their pulse.
    task automatic wait_quiet(input string name, input int budget);
        int  n;
        bit  drop_dc, drop_ic, drop_sb;
        n = 0;
        while ((dc_miss_i || ic_miss_i || sb_req_i || busy_o) && n < budget) begin
            drop_dc = dc_mmu_data_rdy_o;
            drop_ic = ic_mmu_data_rdy_o;
            drop_sb = sb_ack_o;
            tick();
            if (drop_dc) dc_miss_i = 1'b0;
            if (drop_ic) ic_miss_i = 1'b0;
            if (drop_sb) sb_req_i  = 1'b0;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_budget: still active after %0d cycles, required idle", name, n);
        end
        tick();
    endtask

    int unsigned c0;

    initial begin
        rsn = 1'b0;
        dc_miss_i = 0; ic_miss_i = 0; sb_req_i = 0; mem_rdy_i = 0;
        dc_addr_i = '0; ic_addr_i = '0; sb_addr_i = '0; sb_data_i = '0;
        sb_data_type_i = '0; mem_data_i = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", LW'(busy_o), '0);
        chk("rst_mem_rd", LW'(mem_rd_o), '0);
        chk("rst_mem_addr", LW'(mem_addr_o), '0);
        chk("rst_dc_data", dc_data_o, '0);
        chk("rst_timeout", LW'(timeout_o), '0);
        rsn = 1'b1;
        tick();
        clear_logs();

        // Single dcache fill with 4 stalled WAIT cycles
        mem_lat = 4;
        dc_addr_i = 32'h0000_1234; dc_miss_i = 1'b1; c0 = cyc;
        wait_quiet("t1", 40);
        chk("t1_nstrobe", LW'(ev_cyc.size()), LW'(1));
        if (ev_cyc.size() == 1) begin
            chk("t1_addr", LW'(ev_addr[0]), LW'(32'h0000_1230));
            chk("t1_strobe_cyc", LW'(ev_cyc[0]), LW'(c0 + 1));
        end
        chk("t1_ndone", LW'(dc_done_cyc.size()), LW'(1));
        if (dc_done_cyc.size() == 1) chk("t1_done_cyc", LW'(dc_done_cyc[0]), LW'(c0 + 7));
        chk("t1_line", dc_data_o, 128'h00001230_FFFFEDCF_00001231_A5A55A5A);

        // Minimum-latency icache fill; dcache line must hold
        clear_logs(); mem_lat = 0;
        ic_addr_i = 32'h0000_004C; ic_miss_i = 1'b1; c0 = cyc;
        wait_quiet("t1b", 20);
        if (ic_done_cyc.size() == 1) chk("t1b_done_cyc", LW'(ic_done_cyc[0]), LW'(c0 + 3));
        chk("t1b_ndone", LW'(ic_done_cyc.size()), LW'(1));
        chk("t1b_line", ic_data_o, 128'h00000040_FFFFFFBF_00000041_A5A55A5A);
        chk("t1b_dc_hold", dc_data_o, 128'h00001230_FFFFEDCF_00001231_A5A55A5A);

        // dc and ic together after reset: dc first, ic back-to-back
        do_reset(); mem_lat = 1;
        dc_addr_i = 32'h0000_0100; ic_addr_i = 32'h0000_0200;
        dc_miss_i = 1'b1; ic_miss_i = 1'b1; c0 = cyc;
        wait_quiet("t2", 40);
        chk("t2_nstrobe", LW'(ev_cyc.size()), LW'(2));
        if (ev_cyc.size() == 2) begin
            chk("t2_first", LW'(ev_addr[0]), LW'(32'h0000_0100));
            chk("t2_second", LW'(ev_addr[1]), LW'(32'h0000_0200));
            chk("t2_b2b_cyc", LW'(ev_cyc[1]), LW'(c0 + 5));
            chk("t2_rd_only", LW'({ev_wr[0], ev_wr[1]}), '0);
        end

        // Store to the same line as the fill drains first
        clear_logs(); mem_lat = 0;
        sb_addr_i = 32'h0000_0108; sb_data_i = 32'hDEAD_BEEF; sb_data_type_i = MEMOP_WORD;
        dc_addr_i = 32'h0000_0100;
        sb_req_i = 1'b1; dc_miss_i = 1'b1; c0 = cyc;
        wait_quiet("t3", 40);
        chk("t3_nstrobe", LW'(ev_cyc.size()), LW'(2));
        if (ev_cyc.size() == 2) begin
            chk("t3_first_wr", LW'(ev_wr[0]), LW'(1));
            chk("t3_first_addr", LW'(ev_addr[0]), LW'(32'h0000_0108));
            chk("t3_wdata", LW'(ev_wdata[0]), LW'(32'hDEAD_BEEF));
            chk("t3_second_addr", LW'(ev_addr[1]), LW'(32'h0000_0100));
            chk("t3_second_cyc", LW'(ev_cyc[1]), LW'(c0 + 4));
        end
        chk("t3_nack", LW'(sb_ack_cyc.size()), LW'(1));

        // Different line: fill goes first, store after
        clear_logs();
        dc_addr_i = 32'h0000_0200;
        sb_req_i = 1'b1; dc_miss_i = 1'b1; c0 = cyc;
        wait_quiet("t4", 40);
        chk("t4_nstrobe", LW'(ev_cyc.size()), LW'(2));
        if (ev_cyc.size() == 2) begin
            chk("t4_first_addr", LW'(ev_addr[0]), LW'(32'h0000_0200));
            chk("t4_first_rd", LW'(ev_wr[0]), LW'(0));
            chk("t4_second_wr", LW'(ev_wr[1]), LW'(1));
            chk("t4_second_addr", LW'(ev_addr[1]), LW'(32'h0000_0108));
        end

        // Async reset in DCACHE_WAIT abandons the fill
        clear_logs(); mem_lat = 6;
        dc_addr_i = 32'h0000_0300; dc_miss_i = 1'b1; c0 = cyc;
        repeat (3) tick();
        chk("t5_busy_before", LW'(busy_o), LW'(1));
        #2;
        rsn = 1'b0; dc_miss_i = 1'b0;
        #1;
        chk("t5_rst_busy", LW'(busy_o), '0);
        chk("t5_rst_addr", LW'(mem_addr_o), '0);
        chk("t5_rst_dc_data", dc_data_o, '0);
        chk("t5_rst_rd", LW'(mem_rd_o), '0);
        repeat (2) tick();
        rsn = 1'b1;
        repeat (8) tick();
        chk("t5_no_done", LW'(dc_done_cyc.size()), '0);
        chk("t5_idle", LW'(busy_o), '0);

`ifdef SEGRE_MEM_ARB_TIMEOUT_EN
        // Withheld completion: watchdog fires and the fill is reissued
        do_reset(); mem_lat = 0; hold_n = 1;
        ic_addr_i = 32'h0000_0500; ic_miss_i = 1'b1; c0 = cyc;
        wait_quiet("t6", 60);
        chk("t6_nstrobe", LW'(ev_cyc.size()), LW'(2));
        if (ev_cyc.size() == 2) begin
            chk("t6_reissue_addr", LW'(ev_addr[1]), LW'(32'h0000_0500));
            chk("t6_reissue_cyc", LW'(ev_cyc[1]), LW'(c0 + 10));
        end
        if (ic_done_cyc.size() == 1) chk("t6_done_cyc", LW'(ic_done_cyc[0]), LW'(c0 + 12));
        chk("t6_timeout", LW'(timeout_o), LW'(1));
`else
        chk("t6_timeout_tied", LW'(timeout_o), '0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1);
    end

endmodule
